// File: rtl/bram_seq_reader.sv
// Sequential BRAM read-out: sweeps a wrap-around address range and streams the read data
// through a credit-limited FIFO, so backpressure never drops a read.
module bram_seq_reader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] douta,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  localparam int unsigned DEPTH = RD_LAT + 2;
  localparam int unsigned CW    = $clog2(DEPTH + RD_LAT + 1);
  localparam int unsigned LW    = ADDR_W + 1;

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e            state_q, state_d;
  logic [LW-1:0]     len_q, issued_q, pushed_q;
  logic [ADDR_W-1:0] addr_q;
  logic [RD_LAT-1:0] pipe_q;
  logic [DATA_W-1:0] fdata_q [DEPTH];
  logic [DATA_W-1:0] fdata_d [DEPTH];
  logic [DEPTH-1:0]  flast_q, flast_d;
  logic [CW-1:0]     count_q, count_d;
  logic              valid_q;
  logic [CW-1:0]     credit_used;
  logic              accept, push, pop, push_last;

  assign accept    = (state_q == StIdle) && start;
  assign push      = pipe_q[RD_LAT-1];
  assign pop       = valid_q && m_ready;
  assign push_last = (pushed_q + LW'(1)) == len_q;

  // Reads still in the BRAM pipeline plus buffered beats; a same-cycle pop frees nothing.
  always_comb begin
    credit_used = count_q;
    for (int i = 0; i < RD_LAT; i++) begin
      credit_used = credit_used + CW'(pipe_q[i]);
    end
  end

  assign ena = (state_q == StRun) && (issued_q < len_q) && (credit_used < CW'(DEPTH));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = (length == '0) ? StFin : StRun;
      StRun:   if (pop && flast_q[0]) state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Shift FIFO: entry 0 is the output register; vacant entries keep last=0.
  always_comb begin
    fdata_d = fdata_q;
    flast_d = flast_q;
    count_d = count_q;
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        fdata_d[i] = fdata_q[i + 1];
        flast_d[i] = flast_q[i + 1];
      end
      flast_d[DEPTH-1] = 1'b0;
      count_d = count_q - CW'(1);
    end
    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (count_d == CW'(i)) begin
          fdata_d[i] = douta;
          flast_d[i] = push_last;
        end
      end
      count_d = count_d + CW'(1);
    end
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      state_q  <= StIdle;
      len_q    <= '0;
      issued_q <= '0;
      pushed_q <= '0;
      addr_q   <= '0;
      pipe_q   <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      flast_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fdata_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pipe_q  <= (pipe_q << 1) | RD_LAT'(ena);
      if (push) pushed_q <= pushed_q + LW'(1);
      if (accept) begin
        addr_q   <= base_addr;
        len_q    <= length;
        issued_q <= '0;
        pushed_q <= '0;
      end else if (ena) begin
        addr_q   <= addr_q + ADDR_W'(1);
        issued_q <= issued_q + LW'(1);
      end
      count_q <= count_d;
      valid_q <= (count_d != '0);
      flast_q <= flast_d;
      fdata_q <= fdata_d;
    end
  end

  // A zero-length request reports busy alongside its done pulse.
  assign busy    = (state_q == StRun) || ((state_q == StFin) && (len_q == '0));
  assign done    = (state_q == StFin);
  assign wea     = 1'b0;
  assign addra   = addr_q;
  assign m_data  = fdata_q[0];
  assign m_valid = valid_q;
  assign m_last  = flast_q[0];

  a_no_overflow: assert property (@(posedge clka) disable iff (rsta)
    !(push && !pop && (count_q == CW'(DEPTH))));

endmodule

// File: tb/tb_bram_seq_reader.sv
// Bench for bram_seq_reader: two instances (read latency 1 and 2) share all stimulus and are
// checked against a memory image mem[a] = a ^ 0x5A and the stream timing rules.
module tb_bram_seq_reader;

  logic       clka = 1'b0;
  logic       rsta;
  logic       start;
  logic [7:0] base_addr;
  logic [8:0] length;
  logic       mready;

  logic       busy_w [2];
  logic       done_w [2];
  logic       ena_w [2];
  logic       wea_w [2];
  logic [7:0] addra_w [2];
  logic [7:0] dout_w [2];
  logic [7:0] md_w [2];
  logic       mv_w [2];
  logic       ml_w [2];
  logic [7:0] stage1;

  int cyc = 0;
  int t0 = 0;
  logic mon_clr;
  int errors = 0;
  int checks = 0;

  // Monitor records
  logic [7:0] bdat [2][512];
  logic       blast [2][512];
  int         bcyc [2][512];
  logic [7:0] aseq [2][512];
  int nbeat [2];
  int nrd [2];
  int done_cnt [2];
  int done_cyc [2];
  int max_occ [2];
  int stab_err [2];
  int ena_first [2];
  logic busy1 [2];
  logic busy2 [2];
  logic pend_v [2];
  logic [7:0] pend_d [2];
  logic pend_l [2];

  always #5 clka = ~clka;
  always @(posedge clka) cyc <= cyc + 1;

  bram_seq_reader #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) u_dut1 (
    .clka(clka), .rsta(rsta), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy_w[0]), .done(done_w[0]), .ena(ena_w[0]), .wea(wea_w[0]), .addra(addra_w[0]),
    .douta(dout_w[0]), .m_data(md_w[0]), .m_valid(mv_w[0]), .m_ready(mready),
    .m_last(ml_w[0])
  );

  bram_seq_reader #(.ADDR_W(8), .DATA_W(8), .RD_LAT(2)) u_dut2 (
    .clka(clka), .rsta(rsta), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy_w[1]), .done(done_w[1]), .ena(ena_w[1]), .wea(wea_w[1]), .addra(addra_w[1]),
    .douta(dout_w[1]), .m_data(md_w[1]), .m_valid(mv_w[1]), .m_ready(mready),
    .m_last(ml_w[1])
  );

  // BRAM models: latency 1 and latency 2 (output register)
  always @(posedge clka) begin
    if (ena_w[0]) dout_w[0] <= addra_w[0] ^ 8'h5A;
    if (ena_w[1]) stage1 <= addra_w[1] ^ 8'h5A;
    dout_w[1] <= stage1;
  end

  always @(negedge clka) begin
    for (int k = 0; k < 2; k++) begin
      if (mon_clr) begin
        nrd[k]       <= 0;
        nbeat[k]     <= 0;
        done_cnt[k]  <= 0;
        done_cyc[k]  <= -1;
        max_occ[k]   <= 0;
        stab_err[k]  <= 0;
        ena_first[k] <= -1;
        busy1[k]     <= 1'b0;
        busy2[k]     <= 1'b0;
        pend_v[k]    <= 1'b0;
      end else begin
        if (ena_w[k]) begin
          aseq[k][nrd[k] % 512] <= addra_w[k];
          nrd[k] <= nrd[k] + 1;
          if (nrd[k] + 1 - nbeat[k] > max_occ[k]) max_occ[k] <= nrd[k] + 1 - nbeat[k];
          if (ena_first[k] < 0) ena_first[k] <= cyc - t0;
        end
        if (mv_w[k] && mready) begin
          bdat[k][nbeat[k] % 512]  <= md_w[k];
          blast[k][nbeat[k] % 512] <= ml_w[k];
          bcyc[k][nbeat[k] % 512]  <= cyc - t0;
          nbeat[k] <= nbeat[k] + 1;
        end
        if (pend_v[k] && (!mv_w[k] || md_w[k] !== pend_d[k] || ml_w[k] !== pend_l[k]))
          stab_err[k] <= stab_err[k] + 1;
        pend_v[k] <= mv_w[k] && !mready;
        pend_d[k] <= md_w[k];
        pend_l[k] <= ml_w[k];
        if (done_w[k]) begin
          done_cnt[k] <= done_cnt[k] + 1;
          done_cyc[k] <= cyc - t0;
        end
        if (cyc - t0 == 1) busy1[k] <= busy_w[k];
        if (cyc - t0 == 2) busy2[k] <= busy_w[k];
      end
    end
  end

  function automatic logic [7:0] exp_data(input logic [7:0] b, input int i);
    logic [7:0] a;
    a = b + 8'(i);
    return a ^ 8'h5A;
  endfunction

  task automatic launch(input logic [7:0] b, input logic [8:0] n);
    @(posedge clka); #1;
    start = 1'b1;
    base_addr = b;
    length = n;
    t0 = cyc;
    mon_clr = 1'b1;
    @(posedge clka); #1;
    start = 1'b0;
    mon_clr = 1'b0;
  endtask

  // mode 0: ready held high; 1: ready 1,0,0,1 repeating; 2: random ready
  task automatic wait_done(input int budget, input int mode, output logic ok);
    int n;
    n = 0;
    while (!(done_cnt[0] > 0 && done_cnt[1] > 0) && n < budget) begin
      case (mode)
        1:       mready = (n % 4 == 0) || (n % 4 == 3);
        2:       mready = ($urandom_range(0, 9) < 7);
        default: mready = 1'b1;
      endcase
      @(posedge clka); #1;
      n++;
    end
    ok = (n < budget);
    mready = 1'b1;
    repeat (2) @(posedge clka);
    #1;
  endtask

  task automatic test_reset();
    rsta = 1'b1;
    repeat (3) @(posedge clka);
    @(negedge clka);
    for (int k = 0; k < 2; k++) begin
      checks++; if (busy_w[k] !== 1'b0) begin errors++; $display("FAIL reset_busy dut%0d: got %b want 0", k, busy_w[k]); end
      checks++; if (done_w[k] !== 1'b0) begin errors++; $display("FAIL reset_done dut%0d: got %b want 0", k, done_w[k]); end
      checks++; if (ena_w[k] !== 1'b0) begin errors++; $display("FAIL reset_ena dut%0d: got %b want 0", k, ena_w[k]); end
      checks++; if (wea_w[k] !== 1'b0) begin errors++; $display("FAIL reset_wea dut%0d: got %b want 0", k, wea_w[k]); end
      checks++; if (mv_w[k] !== 1'b0) begin errors++; $display("FAIL reset_valid dut%0d: got %b want 0", k, mv_w[k]); end
      checks++; if (ml_w[k] !== 1'b0) begin errors++; $display("FAIL reset_last dut%0d: got %b want 0", k, ml_w[k]); end
      checks++; if (addra_w[k] !== 8'h00) begin errors++; $display("FAIL reset_addra dut%0d: got %h want 00", k, addra_w[k]); end
      checks++; if (md_w[k] !== 8'h00) begin errors++; $display("FAIL reset_mdata dut%0d: got %h want 00", k, md_w[k]); end
    end
    #1 rsta = 1'b0;
    repeat (2) @(posedge clka);
    #1;
  endtask

  task automatic test_basic();
    logic ok;
    int lat;
    launch(8'h10, 9'd4);
    wait_done(100, 0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: done not seen, want done within 100 cycles"); end
    for (int k = 0; k < 2; k++) begin
      lat = k + 1;
      checks++; if (nbeat[k] !== 4) begin errors++; $display("FAIL basic_count dut%0d: got %0d want 4", k, nbeat[k]); end
      checks++; if (ena_first[k] !== 1 || busy1[k] !== 1'b1) begin errors++; $display("FAIL basic_cycle1 dut%0d: ena at %0d busy %b want 1/1", k, ena_first[k], busy1[k]); end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (bdat[k][i] !== exp_data(8'h10, i) || blast[k][i] !== (i == 3) || bcyc[k][i] !== 2 + lat + i) begin
          errors++;
          $display("FAIL basic_beat dut%0d #%0d: got %h last %b cyc %0d want %h last %b cyc %0d", k, i,
                   bdat[k][i], blast[k][i], bcyc[k][i], exp_data(8'h10, i), (i == 3), 2 + lat + i);
        end
      end
      checks++; if (done_cyc[k] !== 6 + lat || done_cnt[k] !== 1) begin errors++; $display("FAIL basic_done dut%0d: got cyc %0d cnt %0d want cyc %0d cnt 1", k, done_cyc[k], done_cnt[k], 6 + lat); end
    end
  endtask

  task automatic test_wrap();
    logic ok;
    logic [7:0] ea;
    launch(8'hFE, 9'd4);
    wait_done(100, 0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout: done not seen, want done within 100 cycles"); end
    for (int k = 0; k < 2; k++) begin
      checks++; if (nrd[k] !== 4 || nbeat[k] !== 4) begin errors++; $display("FAIL wrap_count dut%0d: got reads %0d beats %0d want 4/4", k, nrd[k], nbeat[k]); end
      for (int i = 0; i < 4; i++) begin
        ea = 8'hFE + 8'(i);
        checks++;
        if (aseq[k][i] !== ea || bdat[k][i] !== (ea ^ 8'h5A)) begin
          errors++;
          $display("FAIL wrap_beat dut%0d #%0d: got addr %h data %h want addr %h data %h", k, i, aseq[k][i], bdat[k][i], ea, ea ^ 8'h5A);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic ok;
    int bad;
    launch(8'h40, 9'd16);
    wait_done(200, 1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: done not seen, want done within 200 cycles"); end
    for (int k = 0; k < 2; k++) begin
      bad = 0;
      for (int i = 0; i < 16; i++) if (bdat[k][i] !== exp_data(8'h40, i) || blast[k][i] !== (i == 15)) bad++;
      checks++; if (nbeat[k] !== 16 || nrd[k] !== 16) begin errors++; $display("FAIL bp_count dut%0d: got beats %0d reads %0d want 16/16", k, nbeat[k], nrd[k]); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL bp_order dut%0d: got %0d wrong beats want 0", k, bad); end
      checks++; if (max_occ[k] > k + 3) begin errors++; $display("FAIL bp_credit dut%0d: got occupancy %0d want <= %0d", k, max_occ[k], k + 3); end
      checks++; if (stab_err[k] !== 0) begin errors++; $display("FAIL bp_hold dut%0d: got %0d unstable stalls want 0", k, stab_err[k]); end
    end
  endtask

  task automatic test_zero_len();
    logic ok;
    launch(8'h55, 9'd0);
    wait_done(20, 0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL zero_timeout: done not seen, want done within 20 cycles"); end
    for (int k = 0; k < 2; k++) begin
      checks++; if (done_cyc[k] !== 1 || done_cnt[k] !== 1) begin errors++; $display("FAIL zero_done dut%0d: got cyc %0d cnt %0d want 1/1", k, done_cyc[k], done_cnt[k]); end
      checks++; if (busy1[k] !== 1'b1 || busy2[k] !== 1'b0) begin errors++; $display("FAIL zero_busy dut%0d: got %b%b want 10", k, busy1[k], busy2[k]); end
      checks++; if (nbeat[k] !== 0 || nrd[k] !== 0) begin errors++; $display("FAIL zero_traffic dut%0d: got beats %0d reads %0d want 0/0", k, nbeat[k], nrd[k]); end
    end
  endtask

  task automatic test_full();
    logic ok;
    int bad, distinct;
    bit seen [256];
    launch(8'h80, 9'd256);
    wait_done(400, 0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_timeout: done not seen, want done within 400 cycles"); end
    for (int k = 0; k < 2; k++) begin
      bad = 0;
      distinct = 0;
      for (int a = 0; a < 256; a++) seen[a] = 1'b0;
      for (int i = 0; i < 256; i++) begin
        if (!seen[aseq[k][i]]) distinct++;
        seen[aseq[k][i]] = 1'b1;
        if (bdat[k][i] !== exp_data(8'h80, i) || blast[k][i] !== (i == 255)) bad++;
      end
      checks++; if (nbeat[k] !== 256 || nrd[k] !== 256) begin errors++; $display("FAIL full_count dut%0d: got beats %0d reads %0d want 256/256", k, nbeat[k], nrd[k]); end
      checks++; if (distinct !== 256) begin errors++; $display("FAIL full_cover dut%0d: got %0d distinct addresses want 256", k, distinct); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL full_data dut%0d: got %0d wrong beats want 0", k, bad); end
      checks++; if (bdat[k][255] !== 8'h25 || aseq[k][255] !== 8'h7F) begin errors++; $display("FAIL full_last dut%0d: got %h at %h want 25 at 7f", k, bdat[k][255], aseq[k][255]); end
    end
  endtask

  task automatic test_reset_mid();
    logic ok;
    int n;
    int sd [2];
    int sb [2];
    launch(8'hC0, 9'd20);
    n = 0;
    while (nbeat[1] < 5 && n < 100) begin @(posedge clka); #1; n++; end
    checks++; if (n >= 100) begin errors++; $display("FAIL rmid_timeout: got %0d beats want 5", nbeat[1]); end
    rsta = 1'b1;
    @(posedge clka); #1;
    rsta = 1'b0;
    @(negedge clka);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (mv_w[k] !== 1'b0 || busy_w[k] !== 1'b0 || done_w[k] !== 1'b0 || ena_w[k] !== 1'b0) begin
        errors++;
        $display("FAIL rmid_outputs dut%0d: got valid %b busy %b done %b ena %b want 0000", k, mv_w[k], busy_w[k], done_w[k], ena_w[k]);
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin sd[k] = done_cnt[k]; sb[k] = nbeat[k]; end
    repeat (6) @(posedge clka);
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++; if (done_cnt[k] !== sd[k] || nbeat[k] !== sb[k] || sd[k] !== 0) begin errors++; $display("FAIL rmid_quiet dut%0d: got done %0d beats %0d want done 0 beats %0d", k, done_cnt[k], nbeat[k], sb[k]); end
    end
    launch(8'h3C, 9'd2);
    wait_done(50, 0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rmid_restart_timeout: done not seen, want done within 50 cycles"); end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (nbeat[k] !== 2 || bdat[k][0] !== 8'h66 || bdat[k][1] !== 8'h67 || blast[k][0] !== 1'b0 || blast[k][1] !== 1'b1) begin
        errors++;
        $display("FAIL rmid_restart dut%0d: got %0d beats %h %h want 2 beats 66 67", k, nbeat[k], bdat[k][0], bdat[k][1]);
      end
    end
  endtask

  task automatic test_start_ignored();
    logic ok;
    int bad;
    launch(8'h33, 9'd6);
    @(posedge clka); #1;
    start = 1'b1; base_addr = 8'h00; length = 9'd3;
    @(posedge clka); #1;
    start = 1'b0;
    while (cyc - t0 < 9) begin @(posedge clka); #1; end
    start = 1'b1; base_addr = 8'h77; length = 9'd5;
    @(posedge clka); #1;
    start = 1'b0;
    wait_done(50, 0, ok);
    repeat (3) @(posedge clka);
    #1;
    checks++; if (!ok) begin errors++; $display("FAIL ign_timeout: done not seen, want done within 50 cycles"); end
    for (int k = 0; k < 2; k++) begin
      bad = 0;
      for (int i = 0; i < 6; i++) if (aseq[k][i] !== 8'h33 + 8'(i) || bdat[k][i] !== exp_data(8'h33, i)) bad++;
      checks++; if (nrd[k] !== 6 || nbeat[k] !== 6 || bad !== 0) begin errors++; $display("FAIL ign_transfer dut%0d: got reads %0d beats %0d bad %0d want 6/6/0", k, nrd[k], nbeat[k], bad); end
      checks++; if (done_cnt[k] !== 1 || done_cyc[k] !== 9 + k) begin errors++; $display("FAIL ign_done dut%0d: got cnt %0d cyc %0d want 1 at %0d", k, done_cnt[k], done_cyc[k], 9 + k); end
    end
  endtask

  task automatic test_random();
    logic ok;
    logic [7:0] b;
    int n, bad;
    for (int it = 0; it < 6; it++) begin
      b = 8'($urandom);
      n = $urandom_range(1, 24);
      launch(b, 9'(n));
      wait_done(300, 2, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rand_timeout it%0d: done not seen, want done within 300 cycles", it); end
      for (int k = 0; k < 2; k++) begin
        bad = 0;
        for (int i = 0; i < n; i++) if (bdat[k][i] !== exp_data(b, i) || blast[k][i] !== (i == n - 1)) bad++;
        checks++; if (nbeat[k] !== n || bad !== 0) begin errors++; $display("FAIL rand_stream it%0d dut%0d: got %0d beats %0d bad want %0d beats 0 bad", it, k, nbeat[k], bad, n); end
        checks++; if (stab_err[k] !== 0 || max_occ[k] > k + 3) begin errors++; $display("FAIL rand_flow it%0d dut%0d: got unstable %0d occupancy %0d want 0 and <= %0d", it, k, stab_err[k], max_occ[k], k + 3); end
        checks++; if (done_cnt[k] !== 1) begin errors++; $display("FAIL rand_done it%0d dut%0d: got %0d want 1", it, k, done_cnt[k]); end
      end
    end
  endtask

  initial begin
    rsta = 1'b1;
    start = 1'b0;
    base_addr = 8'h00;
    length = 9'd0;
    mready = 1'b1;
    mon_clr = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_full();
    test_reset_mid();
    test_start_ignored();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
